dmux4way16_stream: RTL and testbench
====================================

# dmux4way16_stream

Four-way 16-bit stream demultiplexer: accepts one word per cycle on a single valid/ready input and steers it to one of four output channels selected by a 2-bit channel field sent with each word. Each output channel has its own small FIFO, so a stalled consumer only blocks words destined for that channel. It sits on the datapath side opposite the 4-way 16-bit selectors, fanning a shared bus out to four independent sinks.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 2, per-channel FIFO entries; power of two, at least 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  input word
- in_sel  input  2  destination channel, 0..3
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept the word on in_sel
- out_data  output  4*WIDTH  channel k data on bits [k*WIDTH +: WIDTH]
- out_valid  output  4  per-channel head-of-FIFO valid
- out_ready  input  4  per-channel consumer ready
- out_count  output  4*16  per-channel accepted-word counters, channel k on bits [k*16 +: 16]

## Operation
- Push: on in_valid && in_ready, the word is written to FIFO[in_sel]. No other FIFO changes.
- in_ready = !full[in_sel]. It is combinational from in_sel and the registered FIFO state only. There is no path from out_ready to in_ready.
- Pop: on out_valid[k] && out_ready[k], FIFO[k] advances. Channels pop independently and simultaneously.
- out_valid[k] = !empty[k]. out_data[k] is the FIFO head and is held stable while out_valid[k] && !out_ready[k].
- Push and pop on the same channel in the same cycle:
  - If the FIFO is neither full nor empty, occupancy is unchanged.
  - If the FIFO is full, in_ready is 0, so only the pop occurs.
  - If the FIFO is empty, the pushed word appears next cycle.
- Word order within a channel is preserved. There is no ordering relation between channels.
- Input rules:
  - The sender holds in_data and in_sel stable while in_valid && !in_ready.
  - Words are never dropped or duplicated.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are taken from an occupancy count of log2(DEPTH)+1 bits.
- Reset (any time, including mid-transfer):
  - All FIFOs flush immediately.
  - out_valid = 0, out_data = 0, out_count = 0.
  - in_ready = 1 after reset, since every FIFO is empty.

## Timing
- Latency: a word accepted at edge t is presented on out_valid[k] and out_data[k] after edge t (visible in cycle t+1). There is no combinational input-to-output path.
- Throughput: 1 word per cycle aggregate. A single channel with out_ready held high sustains 1 word per cycle when DEPTH ≥ 2.
- out_count[k] increments at the same edge as a push to channel k. It wraps from 0xFFFF to 0x0000 and does not saturate.

## Configuration
- DMUX4WAY16_STREAM_COUNT_EN defined: the four 16-bit counters are implemented as described.
- DMUX4WAY16_STREAM_COUNT_EN undefined: no counter registers exist and out_count is tied to 0. All other behaviour is identical.

## Structure
- Shared package hack_stream_pkg holds:
  - HACK_WORD_W = 16
  - channel-count constant NUM_CH = 4
  - channel-index width CH_W = 2
  - the counter width
- One sub-module, dmux4way16_chan_fifo, is instantiated four times. It is a parameterised WIDTH×DEPTH synchronous FIFO with push/pop, full/empty and async active-low reset.
- The top level contains the in_sel decode, the in_ready mux, the output packing and the optional counters.

## Test plan
- Reset state: assert rst_n=0 mid-stream with words buffered -> out_valid=4'b0000, out_count all 0, in_ready=1 in the cycle after release.
- Basic routing: out_ready=4'b1111; send 0x1111/sel0, 0x2222/sel1, 0x3333/sel2, 0x4444/sel3 on consecutive cycles -> each word appears on its own channel one cycle after acceptance; out_count = 1,1,1,1.
- Backpressure isolation: out_ready[2]=0; send 3 words to channel 2 -> in_ready drops after 2 accepts (DEPTH=2). Words with sel=0 are still accepted and delivered while channel 2 stalls.
- Full with simultaneous pop: channel 1 full and out_ready[1] rises -> in_ready for sel=1 stays 0 that cycle, rises the next cycle; order 0xA001, 0xA002, 0xA003 is preserved.
- Streaming: out_ready[3]=1 and 100 back-to-back words 0..99 to channel 3 -> in_ready never drops; output sequence is 0..99, one word per cycle.
- Counter wrap (macro defined): preload by pushing 65536 words to channel 0 -> out_count[0] returns to 0x0000. With the macro undefined -> out_count stays 0 throughout.

Source files
------------

// File: rtl/dmux4way16_stream_pkg.sv
// Shared constants for the Hack 16-bit stream blocks: word width, channel count,
// channel-index width, counter width and a channel-select decoder.
package hack_stream_pkg;

   localparam int HACK_WORD_W = 16;
   localparam int NUM_CH      = 4;
   localparam int CH_W        = 2;
   localparam int CNT_W       = 16;

   function automatic logic [NUM_CH-1:0] ch_decode(input logic [CH_W-1:0] sel);
      logic [NUM_CH-1:0] onehot;
      onehot      = {NUM_CH{1'b0}};
      onehot[sel] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/dmux4way16_chan_fifo.sv
// WIDTH x DEPTH synchronous FIFO for one demux output channel; storage is
// cleared on reset so the head reads zero while empty after reset.
module dmux4way16_chan_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == CNT_FULL);
   assign empty  = (r_count == {(PTR_W + 1){1'b0}});
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign head   = r_mem[r_rd_ptr];

   // Storage write; an empty FIFO written this edge shows the word next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointers wrap modulo DEPTH; occupancy decides full/empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {(PTR_W + 1){1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dmux4way16_stream.sv
// Four-way 16-bit stream demultiplexer with a FIFO per output channel.
// Optional per-channel accepted-word counters: DMUX4WAY16_STREAM_COUNT_EN.
module dmux4way16_stream
   import hack_stream_pkg::*;
#(
   parameter int WIDTH = HACK_WORD_W,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [CH_W-1:0]           in_sel,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [NUM_CH*WIDTH-1:0]   out_data,
   output logic [NUM_CH-1:0]         out_valid,
   input  logic [NUM_CH-1:0]         out_ready,
   output logic [NUM_CH*CNT_W-1:0]   out_count
);

   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_empty;
   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;
   logic [WIDTH-1:0]  w_head [NUM_CH];

   // Readiness depends only on the selected FIFO's registered state.
   assign in_ready  = !w_full[in_sel];
   assign w_push    = (in_valid && in_ready) ? ch_decode(in_sel) : {NUM_CH{1'b0}};
   assign out_valid = ~w_empty;
   assign w_pop     = out_valid & out_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      dmux4way16_chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (w_push[k]),
         .push_data (in_data),
         .pop       (w_pop[k]),
         .full      (w_full[k]),
         .empty     (w_empty[k]),
         .head      (w_head[k])
      );
      assign out_data[k*WIDTH +: WIDTH] = w_head[k];
   end

`ifdef DMUX4WAY16_STREAM_COUNT_EN
   logic [CNT_W-1:0] r_count [NUM_CH];

   // Free-running accepted-word counters; wrap rather than saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_count[i] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_push[i]) begin
               r_count[i] <= r_count[i] + CNT_W'(1);
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
      assign out_count[k*CNT_W +: CNT_W] = r_count[k];
   end
`else
   assign out_count = {(NUM_CH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_dmux4way16_stream.sv
// Scoreboard bench for dmux4way16_stream: per-channel expected-word queues
// filled on acceptance, drained by a monitor on every output handshake.
module tb_dmux4way16_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [63:0] out_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          stalls = 0;
   logic [15:0] exp_q [4][$];
   logic [15:0] exp_cnt [4];

   always #5 clk = ~clk;

   dmux4way16_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_count_vec();
`ifdef DMUX4WAY16_STREAM_COUNT_EN
      return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
`else
      return 64'd0;
`endif
   endfunction

   task automatic note_accept(input logic [15:0] d, input logic [1:0] s);
      exp_q[s].push_back(d);
      exp_cnt[s] = exp_cnt[s] + 16'd1;
   endtask

   // Present a word after the next edge and wait (bounded) for in_ready.
   task automatic send(input logic [15:0] d, input logic [1:0] s);
      int waited;
      bit done;
      waited = 0;
      done   = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      in_sel   = s;
      while (!done && waited < 200) begin
         @(negedge clk);
         if (in_ready) begin
            note_accept(d, s);
            done = 1'b1;
         end else begin
            waited++;
         end
      end
      stalls += waited;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: word %h sel %0d not accepted in %0d cycles", d, s, waited);
         in_valid = 1'b0;
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int left;
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
      for (int c = 0; c < 500 && left != 0; c++) begin
         @(negedge clk);
         left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
      end
      check(name, 64'(left), 64'd0);
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_sel    = 2'd0;
      out_ready = 4'b0000;
      rst_n     = 1'b0;
      for (int k = 0; k < 4; k++) exp_cnt[k] = 16'd0;

      fork
         forever begin
            @(negedge clk);
            if (rst_n) begin
               for (int k = 0; k < 4; k++) begin
                  if (out_valid[k] && out_ready[k]) begin
                     if (exp_q[k].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ch%0d_unexpected: got %h, expected no word", k, out_data[k*16 +: 16]);
                     end else begin
                        check($sformatf("ch%0d_data", k), 64'(out_data[k*16 +: 16]), 64'(exp_q[k].pop_front()));
                     end
                  end
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_count", out_count, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Basic routing
      @(posedge clk);
      #1 out_ready = 4'b1111;
      send(16'h1111, 2'd0);
      send(16'h2222, 2'd1);
      send(16'h3333, 2'd2);
      send(16'h4444, 2'd3);
      idle();
      drain("route_drain");
      check("route_count", out_count, exp_count_vec());

      // One-cycle latency with consumer stalled
      @(posedge clk);
      #1 out_ready = 4'b0000;
      send(16'h5555, 2'd0);
      idle();
      @(negedge clk);
      check("lat_valid", 64'(out_valid), 64'h1);
      check("lat_data", 64'(out_data[15:0]), 64'h5555);
      @(posedge clk);
      #1 out_ready = 4'b1111;
      drain("lat_drain");

      // Backpressure isolation on channel 2
      @(posedge clk);
      #1 out_ready = 4'b1011;
      send(16'hC001, 2'd2);
      send(16'hC002, 2'd2);
      idle();
      @(negedge clk);
      check("bp_ready_ch2", 64'(in_ready), 64'd0);
      check("bp_head_ch2", 64'(out_data[47:32]), 64'hC001);
      stalls = 0;
      send(16'hD001, 2'd0);
      send(16'hD002, 2'd0);
      send(16'hD003, 2'd0);
      idle();
      check("bp_ch0_stalls", 64'(stalls), 64'd0);
      repeat (3) @(negedge clk);
      check("bp_hold_ch2", 64'(out_data[47:32]), 64'hC001);
      check("bp_valid", 64'(out_valid), 64'h4);
      @(posedge clk);
      #1 out_ready = 4'b1111;
      send(16'hC003, 2'd2);
      idle();
      drain("bp_drain");

      // Full FIFO with simultaneous pop
      @(posedge clk);
      #1 out_ready = 4'b1101;
      send(16'hA001, 2'd1);
      send(16'hA002, 2'd1);
      @(posedge clk);
      #1;
      in_data = 16'hA003;
      in_sel  = 2'd1;
      @(negedge clk);
      check("full_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 out_ready = 4'b1111;
      @(negedge clk);
      check("full_pop_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("full_after_pop", 64'(in_ready), 64'd1);
      if (in_ready) note_accept(16'hA003, 2'd1);
      idle();
      drain("full_drain");

      // Back-to-back streaming on channel 3
      stalls = 0;
      for (int i = 0; i < 100; i++) send(16'(i), 2'd3);
      idle();
      check("stream_stalls", 64'(stalls), 64'd0);
      drain("stream_drain");
      check("stream_count", out_count, exp_count_vec());

      // Reset mid-stream with words buffered
      @(posedge clk);
      #1 out_ready = 4'b0000;
      send(16'hB001, 2'd0);
      send(16'hB002, 2'd1);
      send(16'hB003, 2'd1);
      idle();
      @(negedge clk);
      check("pre_rst_valid", 64'(out_valid), 64'h3);
      #1 rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_q[k].delete();
         exp_cnt[k] = 16'd0;
      end
      @(negedge clk);
      check("rst_async_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst2_out_valid", 64'(out_valid), 64'd0);
      check("rst2_out_data", out_data, 64'd0);
      check("rst2_out_count", out_count, 64'd0);
      check("rst2_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 out_ready = 4'b1111;

`ifdef DMUX4WAY16_STREAM_COUNT_EN
      // Counter wrap on channel 0
      for (int i = 0; i < 65536; i++) send(16'(i), 2'd0);
      idle();
      drain("wrap_drain");
      check("wrap_count0", 64'(out_count[15:0]), 64'h0000);
      check("wrap_count_all", out_count, exp_count_vec());
`else
      send(16'h7777, 2'd0);
      send(16'h8888, 2'd3);
      idle();
      drain("nocnt_drain");
      check("count_disabled", out_count, 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
